// File: rtl/mc_mem_stage_pkg.sv
// Shared definitions for the multicycle MIPS memory stage: PC source selects,
// memory FSM encodings and the NOP word used when a read is abandoned.
package mc_defs;

  localparam int DATA_W = 32;

  localparam logic [1:0] PCSRC_INC  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JMP  = 2'b10;
  localparam logic [1:0] PCSRC_HOLD = 2'b11;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RD   = 2'b01,
    MS_WR   = 2'b10
  } mstate_e;

  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/mc_mem_stage_pc_unit.sv
// Program counter register with next-PC select (increment, branch, jump, hold).
module mc_pc_unit
  import mc_defs::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pc,
  input  logic [1:0]        pcsource,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [25:0]       ir_target,
  output logic [DATA_W-1:0] pc
);

  logic [DATA_W-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    case (pcsource)
      PCSRC_INC:  pc_nxt = alu_result;
      PCSRC_BR:   pc_nxt = alu_out;
      PCSRC_JMP:  pc_nxt = {pc[31:28], ir_target, 2'b00};
      default:    pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else if (write_pc)
      pc <= pc_nxt;
  end

endmodule

// File: rtl/mc_mem_stage.sv
// Memory-side stage of the multicycle MIPS datapath: PC/IR/DR ownership and a
// handshaked word memory port with timeout. Optional MC_MISALIGN_CHECK_EN.
module mc_mem_stage
  import mc_defs::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       AW       = 10,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_pc,
  input  logic              iord,
  input  logic              write_mem,
  input  logic              write_dr,
  input  logic              write_ir,
  input  logic [1:0]        pcsource,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] b_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] ir_data,
  output logic [DATA_W-1:0] dr_data,
  output logic              busy,
  output logic              timeout_err,
`ifdef MC_MISALIGN_CHECK_EN
  output logic              misalign_err,
`endif
  output logic              proto_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  mstate_e       st, st_nxt;
  logic [15:0]   cnt;
  logic          dst_ir;
  logic          rd_req, any_req, mis;
  logic [AW-1:0] req_addr;
  logic          unused_addr_bits;

  mc_pc_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk        (clk),
    .rst        (rst),
    .write_pc   (write_pc),
    .pcsource   (pcsource),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .ir_target  (ir_data[25:0]),
    .pc         (pc)
  );

  assign rd_req   = write_ir | write_dr;
  assign any_req  = rd_req | write_mem;
  assign req_addr = iord ? alu_out[AW+1:2] : pc[AW+1:2];
  assign unused_addr_bits = ^{alu_out[DATA_W-1:AW+2], alu_out[1:0]};

`ifdef MC_MISALIGN_CHECK_EN
  assign mis = any_req && (iord ? (|alu_out[1:0]) : (|pc[1:0]));
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      st <= MS_IDLE;
    else
      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      MS_IDLE: begin
        if (rd_req && !mis)
          st_nxt = MS_RD;
        else if (write_mem && !mis)
          st_nxt = MS_WR;
      end
      MS_RD, MS_WR: begin
        if (mem_ack || cnt == TO_LAST)
          st_nxt = MS_IDLE;
      end
      default: st_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
    mem_re = (st == MS_RD);
    mem_we = (st == MS_WR);
  end

  // Request capture, completion/abort and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_data     <= '0;
      dr_data     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cnt         <= '0;
      dst_ir      <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
`ifdef MC_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      busy <= (st_nxt != MS_IDLE);
      if (st == MS_IDLE) begin
        if ((rd_req && write_mem) || (write_ir && write_dr))
          proto_err <= 1'b1;
        if (any_req && mis) begin
`ifdef MC_MISALIGN_CHECK_EN
          misalign_err <= 1'b1;
`endif
          if (write_ir)
            ir_data <= NOP_WORD;
          else if (write_dr)
            dr_data <= NOP_WORD;
        end else if (any_req) begin
          mem_addr <= req_addr;
          cnt      <= '0;
          dst_ir   <= write_ir;
          if (!rd_req)
            mem_wdata <= b_data;
        end
      end else begin
        if (any_req)
          proto_err <= 1'b1;
        if (mem_ack) begin
          if (st == MS_RD) begin
            if (dst_ir)
              ir_data <= mem_rdata;
            else
              dr_data <= mem_rdata;
          end
        end else if (cnt == TO_LAST) begin
          // Abandoned fetch executes as a NOP rather than stale data
          timeout_err <= 1'b1;
          if (st == MS_RD) begin
            if (dst_ir)
              ir_data <= NOP_WORD;
            else
              dr_data <= NOP_WORD;
          end
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_stage.sv
// Directed scoreboard bench for mc_mem_stage (TIMEOUT=4): memory accesses are
// checked by a monitor against a queue of expected transactions.
module tb_mc_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_pc, iord, write_mem, write_dr, write_ir;
  logic [1:0]  pcsource;
  logic [31:0] alu_result, alu_out, b_data;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] pc, ir_data, dr_data;
  logic        busy, timeout_err, proto_err;
`ifdef MC_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_active = 1'b0;

  mc_mem_stage #(.RESET_PC(32'h0), .AW(10), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_pc    (write_pc),
    .iord        (iord),
    .write_mem   (write_mem),
    .write_dr    (write_dr),
    .write_ir    (write_ir),
    .pcsource    (pcsource),
    .alu_result  (alu_result),
    .alu_out     (alu_out),
    .b_data      (b_data),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .pc          (pc),
    .ir_data     (ir_data),
    .dr_data     (dr_data),
    .busy        (busy),
    .timeout_err (timeout_err),
`ifdef MC_MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.we = we;
    a.addr = addr;
    a.wdata = wdata;
    exp_q.push_back(a);
  endtask

  task automatic clear_req();
    write_pc = 1'b0; write_ir = 1'b0; write_dr = 1'b0; write_mem = 1'b0;
  endtask

  // Monitor: every new access start must match the head of the expected queue
  always @(negedge clk) begin
    logic active;
    acc_t e;
    active = mem_re | mem_we;
    if (active && !prev_active) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL acc_unexpected: got re=%b we=%b addr=%0d expected no access", mem_re, mem_we, mem_addr);
      end else begin
        e = exp_q.pop_front();
        chk("acc_we", {31'b0, mem_we}, {31'b0, e.we});
        chk("acc_re", {31'b0, mem_re}, {31'b0, ~e.we});
        chk("acc_addr", {22'b0, mem_addr}, {22'b0, e.addr});
        if (e.we)
          chk("acc_wdata", mem_wdata, e.wdata);
      end
    end
    prev_active = active;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    clear_req();
    iord = 1'b0; pcsource = 2'b00;
    alu_result = '0; alu_out = '0; b_data = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir_data, 32'h0);
    chk("rst_dr", dr_data, 32'h0);
    chk("rst_strobes", {30'b0, mem_re, mem_we}, 32'h0);
    chk("rst_addr", {22'b0, mem_addr}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_errs", {30'b0, timeout_err, proto_err}, 32'h0);

    // Fetch at PC=0 with PC+4 in the same cycle, zero-wait memory
    push_acc(1'b0, 10'd0, 32'h0);
    write_ir = 1'b1; write_pc = 1'b1; pcsource = 2'b00; alu_result = 32'h4;
    tick();
    clear_req();
    chk("fetch_busy_on", {31'b0, busy}, 32'h1);
    chk("fetch_pc_inc", pc, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'h8C01_0004;
    tick();
    mem_ack = 1'b0;
    chk("fetch_ir", ir_data, 32'h8C01_0004);
    chk("fetch_busy_off", {31'b0, busy}, 32'h0);
    chk("fetch_re_off", {31'b0, mem_re}, 32'h0);

    // Branch to 0x4000_0000, fetch a jump, then take it
    write_pc = 1'b1; pcsource = 2'b01; alu_out = 32'h4000_0000;
    tick();
    clear_req();
    chk("pc_branch", pc, 32'h4000_0000);
    push_acc(1'b0, 10'd0, 32'h0);
    write_ir = 1'b1; iord = 1'b0;
    tick();
    clear_req();
    mem_ack = 1'b1; mem_rdata = 32'h0800_0010;
    tick();
    mem_ack = 1'b0;
    chk("jmp_ir", ir_data, 32'h0800_0010);
    write_pc = 1'b1; pcsource = 2'b10;
    tick();
    clear_req();
    chk("pc_jump", pc, 32'h4000_0040);
    write_pc = 1'b1; pcsource = 2'b11; alu_result = 32'h1234_5678;
    tick();
    clear_req();
    chk("pc_hold", pc, 32'h4000_0040);
    pcsource = 2'b00;
    tick();
    chk("pc_nowrite", pc, 32'h4000_0040);

    // Data load into DR from effective address 0x20
    push_acc(1'b0, 10'd8, 32'h0);
    write_dr = 1'b1; iord = 1'b1; alu_out = 32'h0000_0020;
    tick();
    clear_req();
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("dr_load", dr_data, 32'h1234_5678);
    chk("dr_ir_kept", ir_data, 32'h0800_0010);

    // Store with ack in the third wait cycle
    push_acc(1'b1, 10'd64, 32'hDEAD_BEEF);
    write_mem = 1'b1; iord = 1'b1; alu_out = 32'h0000_0100; b_data = 32'hDEAD_BEEF;
    tick();
    clear_req();
    b_data = 32'h0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_we) n++;
      if (i == 2) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("st_we_cycles", n, 3);
    chk("st_we_off", {31'b0, mem_we}, 32'h0);
    chk("st_addr", {22'b0, mem_addr}, 32'd64);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_no_proto", {31'b0, proto_err}, 32'h0);

    // Fetch that never gets an ack
    push_acc(1'b0, 10'd128, 32'h0);
    write_ir = 1'b1; iord = 1'b1; alu_out = 32'h0000_0200;
    tick();
    clear_req();
    chk("to_err_before", {31'b0, timeout_err}, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mem_re) break;
      n++;
      tick();
    end
    chk("to_wait_cycles", n, 4);
    chk("to_err", {31'b0, timeout_err}, 32'h1);
    chk("to_ir_nop", ir_data, 32'h0);
    chk("to_idle", {31'b0, busy}, 32'h0);

    // Read and write together, then a DR request while busy
    push_acc(1'b0, 10'd16, 32'h0);
    write_ir = 1'b1; write_mem = 1'b1; iord = 1'b0; b_data = 32'h5555_AAAA;
    tick();
    clear_req();
    chk("pr_re", {31'b0, mem_re}, 32'h1);
    chk("pr_no_we", {31'b0, mem_we}, 32'h0);
    chk("pr_err", {31'b0, proto_err}, 32'h1);
    write_dr = 1'b1; iord = 1'b1; alu_out = 32'h0000_0300;
    tick();
    clear_req();
    chk("pr_addr_kept", {22'b0, mem_addr}, 32'd16);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 1'b0;
    chk("pr_ir", ir_data, 32'hA5A5_0001);
    chk("pr_dr_kept", dr_data, 32'h1234_5678);
    tick();
    chk("pr_idle", {31'b0, busy}, 32'h0);

    // Reset while a fetch is acked on the same edge
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_ir", ir_data, 32'h0);
    chk("rst2_errs", {30'b0, timeout_err, proto_err}, 32'h0);
    push_acc(1'b0, 10'd0, 32'h0);
    write_ir = 1'b1; iord = 1'b0;
    tick();
    clear_req();
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; mem_ack = 1'b0;
    chk("rstmid_ir", ir_data, 32'h0);
    chk("rstmid_pc", pc, 32'h0);
    chk("rstmid_re", {31'b0, mem_re}, 32'h0);
    chk("rstmid_busy", {31'b0, busy}, 32'h0);

    // IR and DR requested together: IR wins
    push_acc(1'b0, 10'd16, 32'h0);
    write_ir = 1'b1; write_dr = 1'b1; iord = 1'b1; alu_out = 32'h0000_0040;
    tick();
    clear_req();
    chk("irdr_err", {31'b0, proto_err}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    chk("irdr_ir", ir_data, 32'h1111_2222);
    chk("irdr_dr", dr_data, 32'h0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("idleack_ir", ir_data, 32'h1111_2222);
    chk("idleack_dr", dr_data, 32'h0);
    chk("idleack_busy", {31'b0, busy}, 32'h0);

    tick();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
